// File: rtl/taillight_seq_ctrl.sv
// Tail-light sequencer front end: synchronises and debounces the driver
// switches, arbitrates them into a lamp mode, generates the slow step tick
// and runs the 4-phase sweep so that a sweep is only cut short by hazard.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | lamps off, waiting for a request
// ST_RUN   | sweeping in the current mode, request matches mode
// ST_DRAIN | request changed; finish the sweep, adopt new mode on wrap
module taillight_seq_ctrl #(
  parameter int unsigned DIV_W  = 26,
  parameter int unsigned DB_CYC = 16,
  parameter int unsigned DB_W   = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       turn_l,
  input  logic       turn_r,
  input  logic       hazard,
  input  logic       brake,
  output logic [1:0] mode,
  output logic [1:0] phase,
  output logic       step,
  output logic       busy,
  output logic       brake_on
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_HAZ = 2'b11;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  // Index: 0 turn_l, 1 turn_r, 2 hazard, 3 brake
  logic [3:0]           raw;
  logic [3:0]           sync1;
  logic [3:0]           sync2;
  logic [3:0]           deb;
  logic [3:0][DB_W-1:0] db_cnt;

  logic [DIV_W-1:0] presc;
  logic             tick;
  logic [1:0]       req;
  logic [1:0]       state;

  assign raw = {brake, hazard, turn_r, turn_l};

  // Two-flop synchroniser for all four raw switches
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the debounced level only follows after DB_CYC mismatched cycles in a row
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      deb    <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Free-running prescaler; the step tick is its all-ones cycle
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = &presc;

  // Request arbitration: hazard wins, conflicting turn signals mean off
  always_comb begin
    req = MODE_OFF;
    if (deb[2]) begin
      req = MODE_HAZ;
    end else if (deb[0] && !deb[1]) begin
      req = 2'b10;
    end else if (deb[1] && !deb[0]) begin
      req = 2'b01;
    end
  end

  // Sweep sequencer: mode changes wait for the phase wrap unless hazard preempts
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      mode  <= MODE_OFF;
      phase <= 2'd0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req != MODE_OFF) begin
            mode  <= req;
            phase <= 2'd0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (req == MODE_HAZ && mode != MODE_HAZ) begin
            mode  <= MODE_HAZ;
            phase <= 2'd0;
          end else begin
            if (tick) begin
              phase <= phase + 2'd1;
              step  <= 1'b1;
            end
            if (req != mode) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (req == mode) begin
            state <= ST_RUN;
            if (tick) begin
              phase <= phase + 2'd1;
              step  <= 1'b1;
            end
          end else if (req == MODE_HAZ) begin
            mode  <= MODE_HAZ;
            phase <= 2'd0;
            state <= ST_RUN;
          end else if (tick) begin
            step <= 1'b1;
            if (phase == 2'd3) begin
              phase <= 2'd0;
              mode  <= req;
              state <= (req == MODE_OFF) ? ST_IDLE : ST_RUN;
            end else begin
              phase <= phase + 2'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          mode  <= MODE_OFF;
          phase <= 2'd0;
        end
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign brake_on = deb[3];

endmodule

// File: tb/tb_taillight_seq_ctrl.sv
// Directed bench for taillight_seq_ctrl with a short prescaler (tick every
// 8 cycles) and a 4-cycle debounce. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge.
module tb_taillight_seq_ctrl;

  logic       Clk;
  logic       Rst;
  logic       turn_l;
  logic       turn_r;
  logic       hazard;
  logic       brake;
  logic [1:0] mode;
  logic [1:0] phase;
  logic       step;
  logic       busy;
  logic       brake_on;

  int total_cnt = 0;
  int pass_cnt  = 0;

  taillight_seq_ctrl #(
    .DIV_W (3),
    .DB_CYC(4),
    .DB_W  (3)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .turn_l  (turn_l),
    .turn_r  (turn_r),
    .hazard  (hazard),
    .brake   (brake),
    .mode    (mode),
    .phase   (phase),
    .step    (step),
    .busy    (busy),
    .brake_on(brake_on)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Waits (on falling edges) for the next step pulse, up to budget cycles
  task automatic wait_step(input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < budget) begin
      @(negedge Clk);
      waited++;
      if (step === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int bad;
    Rst = 1'b1;
    turn_l = 1'b0; turn_r = 1'b0; hazard = 1'b0; brake = 1'b0;
    repeat (2) @(negedge Clk);
    total_cnt++;
    if ({mode, phase, step, busy, brake_on} !== 7'b0)
      $display("FAIL reset_hold: mode=%b phase=%0d step=%b busy=%b brake_on=%b, want all 0",
               mode, phase, step, busy, brake_on);
    else pass_cnt++;
    Rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if ({mode, phase, step, busy, brake_on} !== 7'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL reset_idle: %0d nonzero cycles, want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int bad;
    for (int g = 0; g < 2; g++) begin
      @(posedge Clk); #1 turn_l = 1'b1;
      repeat (3) @(posedge Clk);
      #1 turn_l = 1'b0;
      bad = 0;
      repeat (10) begin
        @(negedge Clk);
        if (mode !== 2'b00 || busy !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL glitch%0d: %0d cycles with mode!=00, want 0", g, bad);
      else pass_cnt++;
    end
  endtask

  task automatic test_press();
    @(posedge Clk); #1 turn_l = 1'b1;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    total_cnt++;
    if (mode !== 2'b00 || busy !== 1'b0)
      $display("FAIL press_early: mode=%b busy=%b at +6, want 00/0", mode, busy);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if (mode !== 2'b10 || busy !== 1'b1 || phase !== 2'd0 || step !== 1'b0)
      $display("FAIL press_entry: mode=%b busy=%b phase=%0d step=%b at +7, want 10/1/0/0",
               mode, busy, phase, step);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    logic [1:0] eph [4];
    bit ok;
    int w;
    eph = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      wait_step(12, ok, w);
      total_cnt++;
      if (!ok || phase !== eph[i] || mode !== 2'b10 || (i > 0 && w !== 8))
        $display("FAIL sweep%0d: ok=%0d phase=%0d mode=%b interval=%0d, want phase=%0d mode=10 interval=8",
                 i, ok, phase, mode, w, eph[i]);
      else pass_cnt++;
    end
    @(negedge Clk);
    total_cnt++;
    if (step !== 1'b0) $display("FAIL step_width: step=%b one cycle after pulse, want 0", step);
    else pass_cnt++;
  endtask

  task automatic test_change();
    logic [1:0] eph [4];
    logic [1:0] emd [4];
    bit ok;
    int w;
    eph = '{2'd2, 2'd3, 2'd0, 2'd1};
    emd = '{2'b10, 2'b10, 2'b01, 2'b01};
    wait_step(12, ok, w);
    total_cnt++;
    if (!ok || phase !== 2'd1) $display("FAIL change_start: ok=%0d phase=%0d, want phase=1", ok, phase);
    else pass_cnt++;
    @(posedge Clk); #1 turn_l = 1'b0; turn_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_step(12, ok, w);
      total_cnt++;
      if (!ok || phase !== eph[i] || mode !== emd[i] || busy !== 1'b1)
        $display("FAIL change%0d: ok=%0d phase=%0d mode=%b busy=%b, want phase=%0d mode=%b busy=1",
                 i, ok, phase, mode, busy, eph[i], emd[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_hazard();
    logic [1:0] eph [5];
    logic [1:0] emd [5];
    logic [1:0] dph [3];
    logic [1:0] dmd [3];
    bit ok;
    int w;
    eph = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    emd = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    dph = '{2'd2, 2'd3, 2'd0};
    dmd = '{2'b11, 2'b11, 2'b10};
    @(posedge Clk); #1 turn_r = 1'b0; turn_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_step(12, ok, w);
      total_cnt++;
      if (!ok || phase !== eph[i] || mode !== emd[i])
        $display("FAIL back_left%0d: ok=%0d phase=%0d mode=%b, want phase=%0d mode=%b",
                 i, ok, phase, mode, eph[i], emd[i]);
      else pass_cnt++;
    end
    @(posedge Clk); #1 hazard = 1'b1;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    total_cnt++;
    if (mode !== 2'b10 || phase !== 2'd2 || step !== 1'b0)
      $display("FAIL haz_before: mode=%b phase=%0d step=%b, want 10/2/0", mode, phase, step);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if (mode !== 2'b11 || phase !== 2'd0 || step !== 1'b0 || busy !== 1'b1)
      $display("FAIL haz_preempt: mode=%b phase=%0d step=%b busy=%b, want 11/0/0/1",
               mode, phase, step, busy);
    else pass_cnt++;
    wait_step(12, ok, w);
    total_cnt++;
    if (!ok || phase !== 2'd1 || mode !== 2'b11 || w !== 8)
      $display("FAIL haz_run: ok=%0d phase=%0d mode=%b interval=%0d, want 1/11/8", ok, phase, mode, w);
    else pass_cnt++;
    @(posedge Clk); #1 hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_step(12, ok, w);
      total_cnt++;
      if (!ok || phase !== dph[i] || mode !== dmd[i])
        $display("FAIL haz_drop%0d: ok=%0d phase=%0d mode=%b, want phase=%0d mode=%b",
                 i, ok, phase, mode, dph[i], dmd[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_both_brake();
    logic [1:0] eph [4];
    logic [1:0] emd [4];
    logic       ebz [4];
    bit ok;
    int w;
    int bad;
    eph = '{2'd1, 2'd2, 2'd3, 2'd0};
    emd = '{2'b10, 2'b10, 2'b10, 2'b00};
    ebz = '{1'b1, 1'b1, 1'b1, 1'b0};
    @(posedge Clk); #1 turn_r = 1'b1; brake = 1'b1;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    total_cnt++;
    if (brake_on !== 1'b0) $display("FAIL brake_early: brake_on=%b at +5, want 0", brake_on);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if (brake_on !== 1'b1 || mode !== 2'b10 || phase !== 2'd0)
      $display("FAIL brake_on: brake_on=%b mode=%b phase=%0d at +6, want 1/10/0", brake_on, mode, phase);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      wait_step(12, ok, w);
      total_cnt++;
      if (!ok || phase !== eph[i] || mode !== emd[i] || busy !== ebz[i] || brake_on !== 1'b1)
        $display("FAIL both%0d: ok=%0d phase=%0d mode=%b busy=%b brake_on=%b, want phase=%0d mode=%b busy=%b brake_on=1",
                 i, ok, phase, mode, busy, brake_on, eph[i], emd[i], ebz[i]);
      else pass_cnt++;
    end
    bad = 0;
    repeat (12) begin
      @(negedge Clk);
      if (step !== 1'b0 || mode !== 2'b00 || busy !== 1'b0 || phase !== 2'd0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL both_idle: %0d active cycles in idle, want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    int w;
    int bad;
    @(posedge Clk); #1 turn_r = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      wait_step(20, ok, w);
      if (ok && phase === 2'd2 && mode === 2'b10) found = 1'b1;
    end
    total_cnt++;
    if (!found) $display("FAIL rst_mid_setup: no step with mode=10 phase=2 seen, want one");
    else pass_cnt++;
    #2;
    Rst = 1'b1;
    turn_l = 1'b0; brake = 1'b0;
    #1;
    total_cnt++;
    if ({mode, phase, step, busy, brake_on} !== 7'b0)
      $display("FAIL rst_mid: mode=%b phase=%0d step=%b busy=%b brake_on=%b, want all 0",
               mode, phase, step, busy, brake_on);
    else pass_cnt++;
    @(negedge Clk);
    Rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if ({mode, phase, step, busy, brake_on} !== 7'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL rst_mid_after: %0d nonzero cycles, want 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_sweep();
    test_change();
    test_hazard();
    test_both_brake();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
